sipo_frame_ctrl: RTL and testbench
==================================

// Module: sipo_frame_ctrl
// PURPOSE
//  Frame controller for the 4-bit serial-in/parallel-out shift path: sequences bit capture,
//  counts bits, presents a completed word on a valid/ready handshake, flags overrun.
//  Sits between a serial bit source (start/bit_valid qualified) and a parallel word consumer.
// PARAMETERS
//  WIDTH   4  bits per frame / parallel word width (>=2)
//  FCNT_W  8  width of accepted-frame counter
//  CNT_W   $clog2(WIDTH) (localparam)  bit-counter width
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  reset        in   1       synchronous, active-high; clears all state
//  start        in   1       begin new frame (pulse)
//  abort        in   1       discard frame in progress
//  serial_in    in   1       serial data bit
//  bit_valid    in   1       serial_in is valid this cycle
//  out_ready    in   1       consumer accepts out_data
//  clr_overrun  in   1       clears sticky overrun
//  out_data     out  WIDTH   completed word, first-received bit in MSB
//  out_valid    out  1       out_data valid
//  busy         out  1       high in SHIFT or HOLD
//  bit_cnt      out  CNT_W   bits captured in current frame
//  overrun      out  1       sticky: bit arrived while word unconsumed
//  frame_cnt    out  FCNT_W  words accepted by consumer, wraps
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; out_data, out_valid, busy, bit_cnt, overrun,
//   frame_cnt, shift reg all 0. Reset mid-frame discards everything; takes priority over all.
//  States: IDLE=00, SHIFT=01, HOLD=10 (11 unreachable -> IDLE).
//  IDLE: bit_valid ignored. start=1 -> SHIFT, shift reg and bit_cnt cleared. Bit on start cycle
//   is NOT captured; capture begins the following cycle.
//  SHIFT: bit_valid=1 -> shreg <= {shreg[WIDTH-2:0], serial_in}, bit_cnt+1. bit_valid=0 -> hold.
//   On WIDTH-th captured bit (bit_cnt==WIDTH-1 && bit_valid): out_data <= final shifted word,
//   out_valid=1 and state=HOLD next cycle (latency 1 clk after last bit), bit_cnt -> 0.
//   Priority in SHIFT: abort > start > bit_valid. abort -> IDLE, partial word discarded,
//   out_valid stays 0, frame_cnt unchanged. start -> restart frame (clear shreg/bit_cnt).
//  HOLD: out_valid=1, out_data stable until accepted. out_valid && out_ready -> out_valid=0
//   next cycle, frame_cnt+1 (wraps 2^FCNT_W-1 -> 0); next state SHIFT if start same cycle
//   (back-to-back, shreg cleared) else IDLE. abort ignored in HOLD.
//   bit_valid=1 in HOLD (incl. acceptance cycle) -> bit dropped, overrun<=1.
//  overrun: sticky; clr_overrun clears; set wins if set and clear coincide.
//  busy = (state != IDLE), registered with state.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package sipo_ctrl_pkg: state encodings (ST_IDLE/ST_SHIFT/ST_HOLD), state width constant.
//  Sub-module sipo_shift_stage: WIDTH-bit left shift register (clr, shift_en, serial_in,
//   q); controller drives clr/shift_en. FSM, bit counter, handshake, counters in top.
// TESTING (WIDTH=4, FCNT_W=8)
//  1 reset=1 for 2 clks mid-SHIFT -> all outputs 0, state IDLE, next start works normally.
//  2 start; bits 1,0,1,1 on 4 consecutive cycles -> out_valid=1 one clk after 4th bit,
//    out_data=4'b1011; out_ready=1 -> out_valid=0 next clk, frame_cnt=1, busy=0.
//  3 start; bit_valid pattern 1,0,1,0,1,1 with serial_in 1,x,1,x,0,0 -> bit_cnt 1,1,2,2,3,0,
//    out_data=4'b1100.
//  4 word in HOLD, out_ready=0 for 5 clks, bit_valid=1 once -> out_data stable, overrun=1;
//    clr_overrun=1 -> overrun=0 next clk.
//  5 start; 2 bits; abort -> busy=0 next clk, out_valid never asserts, frame_cnt unchanged;
//    abort+bit_valid same cycle -> bit not captured.
//  6 HOLD with out_ready=1 and start same cycle -> SHIFT; bits 0,1,1,0 -> out_data=4'b0110;
//    after 256 accepted frames frame_cnt wraps 255 -> 0.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg: state encodings shared by the serial-in/parallel-out frame controller
package sipo_ctrl_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;
endpackage

// File: rtl/sipo_shift_stage.sv
// sipo_shift_stage: WIDTH-bit left shift register, first-received bit ends up in the MSB
module sipo_shift_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (shift_en) q <= {q[WIDTH-2:0], serial_in};
  end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: sequences serial bit capture into WIDTH-bit words and hands them off on valid/ready
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int FCNT_W = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              serial_in,
  input  logic              bit_valid,
  input  logic              out_ready,
  input  logic              clr_overrun,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    data_q, data_d, shreg;
  logic                valid_q, valid_d, ovr_q, ovr_d, clr, shift_en;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  sipo_shift_stage #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift_en (shift_en),
    .serial_in(serial_in),
    .q        (shreg)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fcnt_d   = fcnt_q;
    ovr_d    = clr_overrun ? 1'b0 : ovr_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (start) begin
          cnt_d = '0;
          clr   = 1'b1;
        end else if (bit_valid) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            data_d  = {shreg[WIDTH-2:0], serial_in};
            valid_d = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bit_valid) ovr_d = 1'b1;
        if (out_ready) begin
          valid_d = 1'b0;
          fcnt_d  = fcnt_q + FCNT_W'(1);
          state_d = start ? ST_SHIFT : ST_IDLE;
          clr     = start;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign bit_cnt   = cnt_q;
  assign overrun   = ovr_q;
  assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: scoreboard bench for the 4-bit frame controller
module tb_sipo_frame_ctrl;
  logic       clk = 0, reset = 0, start = 0, abort = 0, serial_in = 0, bit_valid = 0;
  logic       out_ready = 0, clr_overrun = 0;
  logic [3:0] out_data;
  logic       out_valid, busy, overrun;
  logic [1:0] bit_cnt;
  logic [7:0] frame_cnt;
  logic [3:0] sb[$];
  logic [7:0] exp_fc = 0;
  int         nvec = 0, nerr = 0;

  sipo_frame_ctrl #(.WIDTH(4), .FCNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .serial_in(serial_in),
    .bit_valid(bit_valid), .out_ready(out_ready), .clr_overrun(clr_overrun),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .bit_cnt(bit_cnt),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] w);
    start = 1;
    tick();
    start = 0;
    for (int i = 3; i >= 0; i--) begin
      bit_valid = 1;
      serial_in = w[i];
      if (i == 0) sb.push_back(w);
      tick();
    end
    bit_valid = 0;
    nvec++;
    if (out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL frame_valid: out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic accept();
    logic [3:0] e;
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    nvec++;
    if (sb.size() == 0 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL accept_wait: out_valid=%b queued=%0d", out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    if (out_data !== e) begin
      nerr++;
      $display("FAIL out_data: got %b want %b", out_data, e);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    exp_fc++;
    nvec++;
    if (out_valid !== 1'b0 || frame_cnt !== exp_fc || busy !== 1'b0) begin
      nerr++;
      $display("FAIL post_accept: valid=%b fc=%0d busy=%b want 0 %0d 0", out_valid, frame_cnt, busy, exp_fc);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    start = 1;
    tick();
    start = 0;
    bit_valid = 1;
    serial_in = 1;
    tick();
    tick();
    bit_valid = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    nvec++;
    if ({out_data, out_valid, busy, bit_cnt, overrun, frame_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_state: data=%b v=%b busy=%b cnt=%0d ovr=%b fc=%0d want all 0",
               out_data, out_valid, busy, bit_cnt, overrun, frame_cnt);
    end
  endtask

  task automatic test_basic();
    send_frame(4'b1011);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL hold_busy: busy=%b want 1", busy);
    end
    accept();
  endtask

  task automatic test_gaps();
    logic [5:0] bv = 6'b101011, si = 6'b101000;
    logic [1:0] ec[6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    start = 1;
    tick();
    start = 0;
    sb.push_back(4'b1100);
    for (int i = 0; i < 6; i++) begin
      bit_valid = bv[5-i];
      serial_in = si[5-i];
      tick();
      nvec++;
      if (bit_cnt !== ec[i]) begin
        nerr++;
        $display("FAIL gap_bit_cnt[%0d]: got %0d want %0d", i, bit_cnt, ec[i]);
      end
    end
    bit_valid = 0;
    accept();
  endtask

  task automatic test_overrun();
    send_frame(4'b1001);
    for (int i = 0; i < 5; i++) begin
      bit_valid = (i == 1);
      serial_in = 1;
      tick();
      nvec++;
      if (out_data !== sb[0] || out_valid !== 1'b1 || overrun !== (i >= 1)) begin
        nerr++;
        $display("FAIL hold_stable[%0d]: data=%b v=%b ovr=%b want %b 1 %b", i, out_data, out_valid, overrun, sb[0], i >= 1);
      end
    end
    bit_valid = 0;
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    nvec++;
    if (overrun !== 1'b0) begin
      nerr++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
    accept();
  endtask

  task automatic test_abort();
    start = 1;
    tick();
    start = 0;
    bit_valid = 1;
    tick();
    tick();
    bit_valid = 0;
    abort = 1;
    tick();
    abort = 0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== exp_fc) begin
        nerr++;
        $display("FAIL abort[%0d]: busy=%b v=%b fc=%0d want 0 0 %0d", i, busy, out_valid, frame_cnt, exp_fc);
      end
      tick();
    end
    start = 1;
    tick();
    start = 0;
    bit_valid = 1;
    tick();
    tick();
    tick();
    abort = 1;
    tick();
    abort = 0;
    bit_valid = 0;
    tick();
    nvec++;
    if (out_valid !== 1'b0 || bit_cnt !== 2'd0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL abort_bit: v=%b cnt=%0d busy=%b want 0 0 0", out_valid, bit_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w = 4'b0110;
    send_frame(4'b1110);
    void'(sb.pop_front());
    out_ready = 1;
    start = 1;
    tick();
    out_ready = 0;
    start = 0;
    exp_fc++;
    nvec++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || frame_cnt !== exp_fc) begin
      nerr++;
      $display("FAIL b2b_handoff: busy=%b v=%b fc=%0d want 1 0 %0d", busy, out_valid, frame_cnt, exp_fc);
    end
    for (int i = 3; i >= 0; i--) begin
      bit_valid = 1;
      serial_in = w[i];
      tick();
    end
    bit_valid = 0;
    sb.push_back(w);
    accept();
    while (exp_fc != 8'd255) begin
      send_frame(4'($urandom_range(0, 15)));
      accept();
    end
    nvec++;
    if (frame_cnt !== 8'd255) begin
      nerr++;
      $display("FAIL fc_pre_wrap: got %0d want 255", frame_cnt);
    end
    send_frame(4'b0101);
    accept();
    nvec++;
    if (frame_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL fc_wrap: got %0d want 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
